// File: rtl/bm_sop_window_accum_pkg.sv
// Shared widths, window length and state encoding for the sum-of-products
// window accumulator and its bench.
package bm_sop_window_accum_pkg;

  localparam int IN_W_DEF  = 18;
  localparam int ACC_W_DEF = 20;
  localparam int COUNT_DEF = 8;
  localparam int CNT_W_DEF = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_e;

endpackage

// File: rtl/bm_sat_add.sv
// Unsigned saturating adder: widens an IN_W sample onto an ACC_W running sum
// and clamps to all-ones when the carry out of ACC_W bits is set.
module bm_sat_add
  import bm_sop_window_accum_pkg::*;
#(
  parameter int IN_W  = IN_W_DEF,
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic [ACC_W-1:0] a,
  input  logic [IN_W-1:0]  b,
  output logic [ACC_W-1:0] sum,
  output logic             sat
);

  logic [ACC_W:0] wide;

  assign wide = {1'b0, a} + {{(ACC_W + 1 - IN_W){1'b0}}, b};
  assign sat  = wide[ACC_W];
  assign sum  = sat ? {ACC_W{1'b1}} : wide[ACC_W-1:0];

endmodule

// File: rtl/bm_sop_window_accum.sv
// Accumulates COUNT upstream sum-of-products results (or fewer on flush) into a
// saturating window sum and presents each window on a registered valid/ready port.
module bm_sop_window_accum
  import bm_sop_window_accum_pkg::*;
#(
  parameter int IN_W  = IN_W_DEF,
  parameter int ACC_W = ACC_W_DEF,
  parameter int COUNT = COUNT_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  input  logic [IN_W-1:0]  in_data,
  output logic             in_ready,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_data,
  output logic [CNT_W-1:0] out_count,
  output logic             out_ovf,
  output logic             busy
);

  state_e           state_q;
  logic [ACC_W-1:0] acc_q;
  logic [CNT_W-1:0] cnt_q;
  logic             ovf_q;
  logic             outValid_q;
  logic [ACC_W-1:0] outData_q;
  logic [CNT_W-1:0] outCount_q;
  logic             outOvf_q;

  logic             accept;
  logic             stall;
  logic             lastSlot;
  logic             flushEff;
  logic             closeWin;
  logic [IN_W-1:0]  addIn;
  logic [ACC_W-1:0] sum_d;
  logic             sat_d;
  logic [CNT_W-1:0] cntInc_d;

  // A stalled output can only block the cycle that would close a window,
  // so in_ready never depends on in_valid.
  assign stall    = outValid_q & ~out_ready;
  assign lastSlot = (cnt_q == CNT_W'(COUNT - 1));
  assign in_ready = ~(stall & (lastSlot | flush));
  assign accept   = in_valid & in_ready;
  assign flushEff = flush & ~stall;
  assign closeWin = (accept & lastSlot) | (flushEff & ((cnt_q != '0) | accept));

  assign addIn    = accept ? in_data : '0;
  assign cntInc_d = cnt_q + CNT_W'(accept);

  bm_sat_add #(
    .IN_W (IN_W),
    .ACC_W(ACC_W)
  ) u_sat_add (
    .a  (acc_q),
    .b  (addIn),
    .sum(sum_d),
    .sat(sat_d)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      acc_q      <= '0;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
      outValid_q <= 1'b0;
      outData_q  <= '0;
      outCount_q <= '0;
      outOvf_q   <= 1'b0;
    end else begin
      if (closeWin) begin
        state_q <= IDLE;
        acc_q   <= '0;
        cnt_q   <= '0;
        ovf_q   <= 1'b0;
      end else if (accept) begin
        state_q <= ACCUM;
        acc_q   <= sum_d;
        cnt_q   <= cntInc_d;
        ovf_q   <= ovf_q | sat_d;
      end

      // A drain and a new close in the same cycle reload the output directly.
      if (closeWin) begin
        outValid_q <= 1'b1;
        outData_q  <= sum_d;
        outCount_q <= cntInc_d;
        outOvf_q   <= ovf_q | sat_d;
      end else if (out_ready) begin
        outValid_q <= 1'b0;
      end
    end
  end

  assign out_valid = outValid_q;
  assign out_data  = outData_q;
  assign out_count = outCount_q;
  assign out_ovf   = outOvf_q;
  assign busy      = (state_q == ACCUM);

endmodule

// File: tb/tb_bm_sop_window_accum.sv
// Randomised and directed bench for bm_sop_window_accum with a window-level
// reference model feeding a scoreboard queue drained by an output monitor.
module tb_bm_sop_window_accum;
  import bm_sop_window_accum_pkg::*;

  localparam int  IN_W  = IN_W_DEF;
  localparam int  ACC_W = ACC_W_DEF;
  localparam int  COUNT = COUNT_DEF;
  localparam int  CNT_W = CNT_W_DEF;
  localparam longint MAXV = (longint'(1) << ACC_W) - 1;

  typedef struct {
    longint data;
    int     cnt;
    bit     ovf;
  } exp_t;

  logic             clock = 1'b0;
  logic             reset_n = 1'b0;
  logic             in_valid = 1'b0;
  logic [IN_W-1:0]  in_data = '0;
  logic             in_ready;
  logic             flush = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [ACC_W-1:0] out_data;
  logic [CNT_W-1:0] out_count;
  logic             out_ovf;
  logic             busy;

  int     errors = 0;
  int     checks = 0;
  exp_t   expQ[$];
  int     winCnt = 0;
  longint winSum = 0;
  bit     expectValidNext = 0;

  bm_sop_window_accum #(
    .IN_W (IN_W),
    .ACC_W(ACC_W),
    .COUNT(COUNT),
    .CNT_W(CNT_W)
  ) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .flush    (flush),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_count(out_count),
    .out_ovf  (out_ovf),
    .busy     (busy)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  // Drives one cycle (called just after a rising edge) and advances the window model.
  task automatic applyStimulus(input logic v, input logic [IN_W-1:0] d,
                               input logic f, input logic r);
    bit  stall, expRdy, acc, closeNow;
    exp_t e;
    in_valid  = v;
    in_data   = d;
    flush     = f;
    out_ready = r;
    @(negedge clock);
    if (expectValidNext) checkOutput("latency_out_valid", longint'(out_valid), 1);
    stall  = out_valid && !out_ready;
    expRdy = !(stall && (winCnt == COUNT - 1 || f));
    checkOutput("in_ready", longint'(in_ready), longint'(expRdy));
    checkOutput("busy", longint'(busy), longint'(winCnt != 0));
    acc      = v && in_ready;
    closeNow = (acc && winCnt == COUNT - 1) || (f && !stall && (winCnt != 0 || acc));
    if (acc) begin
      winSum += longint'(d);
      winCnt++;
    end
    if (closeNow) begin
      e.data = (winSum > MAXV) ? MAXV : winSum;
      e.cnt  = winCnt;
      e.ovf  = (winSum > MAXV);
      expQ.push_back(e);
      winSum = 0;
      winCnt = 0;
    end
    expectValidNext = closeNow;
    @(posedge clock);
    #1;
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, 1'b0, 1'b1);
  endtask

  // Monitor: every handshake on the output port consumes one scoreboard entry.
  always @(negedge clock) begin
    if (reset_n && out_valid && out_ready) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpected_output", 1, 0);
      end else begin
        exp_t e;
        e = expQ.pop_front();
        checkOutput("out_data", longint'(out_data), e.data);
        checkOutput("out_count", longint'(out_count), longint'(e.cnt));
        checkOutput("out_ovf", longint'(out_ovf), longint'(e.ovf));
      end
    end
  end

  initial begin
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    @(posedge clock);
    #1;
    checkOutput("reset_out_valid", longint'(out_valid), 0);
    checkOutput("reset_busy", longint'(busy), 0);

    // Reset mid-window, asserted between clock edges.
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 18'd100, 1'b0, 1'b1);
    in_valid = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    checkOutput("async_rst_busy", longint'(busy), 0);
    checkOutput("async_rst_out_valid", longint'(out_valid), 0);
    checkOutput("async_rst_out_data", longint'(out_data), 0);
    checkOutput("async_rst_out_count", longint'(out_count), 0);
    checkOutput("async_rst_out_ovf", longint'(out_ovf), 0);
    expQ.delete();
    winCnt = 0;
    winSum = 0;
    expectValidNext = 0;
    @(posedge clock);
    #2 reset_n = 1'b1;
    @(posedge clock);
    #1;
    for (int i = 0; i < COUNT; i++) applyStimulus(1'b1, 18'd1, 1'b0, 1'b1);
    idleCycles(2);

    // Full window 1..8.
    for (int i = 1; i <= COUNT; i++) applyStimulus(1'b1, IN_W'(i), 1'b0, 1'b1);
    idleCycles(2);

    // Saturating window, then a clean one.
    for (int i = 0; i < COUNT; i++) applyStimulus(1'b1, 18'd262143, 1'b0, 1'b1);
    for (int i = 0; i < COUNT; i++) applyStimulus(1'b1, 18'd10, 1'b0, 1'b1);
    idleCycles(2);

    // Flush cases.
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 18'd5, 1'b0, 1'b1);
    applyStimulus(1'b0, '0, 1'b1, 1'b1);
    applyStimulus(1'b1, 18'd7, 1'b1, 1'b1);
    applyStimulus(1'b0, '0, 1'b0, 1'b1);
    applyStimulus(1'b0, '0, 1'b1, 1'b1);
    idleCycles(2);

    // Backpressure: window A held while window B fills up.
    for (int i = 0; i < COUNT; i++) applyStimulus(1'b1, 18'd2, 1'b0, 1'b0);
    for (int i = 0; i < COUNT - 1; i++) applyStimulus(1'b1, 18'd3, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b1, 18'd3, 1'b0, 1'b0);
      checkOutput("held_out_data", longint'(out_data), 16);
    end
    applyStimulus(1'b1, 18'd3, 1'b0, 1'b1);
    idleCycles(3);

    // Random stream with random backpressure and occasional flush.
    for (int i = 0; i < 64; i++) begin
      applyStimulus(($urandom_range(0, 3) != 0), IN_W'($urandom_range(0, 262143)),
                    ($urandom_range(0, 9) == 0), ($urandom_range(0, 2) != 0));
    end

    for (int i = 0; i < 40 && (expQ.size() != 0 || winCnt != 0); i++) begin
      applyStimulus(1'b0, '0, (winCnt != 0), 1'b1);
    end
    idleCycles(2);
    checkOutput("scoreboard_drained", longint'(expQ.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
